// File: rtl/boot_mem_responder_if.sv
// Bus bundle for boot_mem_responder: data port, instruction fetch port and
// byte-stream loader port. The responder takes the slave side and the
// requester (core model or bench) takes the master side.
interface boot_mem_responder_if #(
   parameter int ADDR_W = 12
);
   // Data port
   logic [29:0]     IN_MEM_addr;
   logic [31:0]     IN_MEM_writeData;
   logic            IN_MEM_writeEnable;   // active low
   logic            IN_MEM_readEnable;    // active low chip enable
   logic [3:0]      IN_MEM_writeMask;     // active high, bit i = byte i
   logic [31:0]     OUT_MEM_readData;

   // Instruction fetch port, addressed in 64-bit units
   logic [28:0]     IN_instrAddr;
   logic            IN_instrReadEnable;   // active low
   logic [63:0]     OUT_instrRaw;

   // Loader port
   logic            IN_LD_start;
   logic [ADDR_W-1:0] IN_LD_baseAddr;
   logic [ADDR_W:0] IN_LD_numWords;
   logic            IN_LD_valid;
   logic [7:0]      IN_LD_byte;
   logic            OUT_LD_ready;
   logic            OUT_coreEn;
   logic            OUT_LD_done;
   logic            OUT_addrError;

   modport slave (
      input  IN_MEM_addr, IN_MEM_writeData, IN_MEM_writeEnable,
             IN_MEM_readEnable, IN_MEM_writeMask,
             IN_instrAddr, IN_instrReadEnable,
             IN_LD_start, IN_LD_baseAddr, IN_LD_numWords, IN_LD_valid, IN_LD_byte,
      output OUT_MEM_readData, OUT_instrRaw,
             OUT_LD_ready, OUT_coreEn, OUT_LD_done, OUT_addrError
   );

   modport master (
      output IN_MEM_addr, IN_MEM_writeData, IN_MEM_writeEnable,
             IN_MEM_readEnable, IN_MEM_writeMask,
             IN_instrAddr, IN_instrReadEnable,
             IN_LD_start, IN_LD_baseAddr, IN_LD_numWords, IN_LD_valid, IN_LD_byte,
      input  OUT_MEM_readData, OUT_instrRaw,
             OUT_LD_ready, OUT_coreEn, OUT_LD_done, OUT_addrError
   );
endinterface

// File: rtl/boot_mem_responder.sv
// Boot memory responder. A byte-stream loader fills 32-bit words into a
// 2^ADDR_W-word store; once loading completes the core is enabled and the
// store serves a registered data port (byte-masked writes) and a registered
// 64-bit instruction fetch port. Any out-of-range access reads as zero, is
// never wrapped, and raises a sticky error flag.
module boot_mem_responder #(
   parameter int ADDR_W = 12
) (
   input logic clk,
   input logic rst,
   boot_mem_responder_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } ldState_t;

   ldState_t          state;
   logic [ADDR_W:0]   ptr;          // one spare bit so overruns past the top are visible
   logic [ADDR_W:0]   remaining;
   logic [1:0]        byteIdx;
   logic [23:0]       asmWord;      // first three bytes of the word in flight
   logic              ldReady;
   logic              coreEn;
   logic              ldDone;
   logic              addrError;
   logic [31:0]       readData;
   logic [63:0]       instrRaw;

   logic [31:0]       mem [DEPTH];

   logic              byteAccept;
   logic              ldWordDone;
   logic              ldOor;
   logic              ldWrite;
   logic [31:0]       ldWord;
   logic              dataAccess;
   logic              dataOor;
   logic              dataRdCmd;
   logic              dataWrite;
   logic [ADDR_W-1:0] dataIdx;
   logic [29:0]       fetchHiAddr;
   logic              fetch;
   logic              fetchOor;
   logic [ADDR_W-1:0] fetchLoIdx;
   logic [ADDR_W-1:0] fetchHiIdx;
   logic              errSet;

   // Decode loader, data and fetch requests into enables and range flags.
   // NOTE: every signal here is assigned on every pass with no branches, so
   // no storage (latch) can be inferred from this block.
   always_comb begin
      byteAccept  = (state == LOAD) && bus.IN_LD_valid && ldReady;
      ldWordDone  = byteAccept && (byteIdx == 2'd3);
      ldOor       = ptr[ADDR_W];
      ldWrite     = ldWordDone && !ldOor;
      ldWord      = {bus.IN_LD_byte, asmWord};

      dataAccess  = (state == DONE) && !bus.IN_MEM_readEnable;
      dataOor     = |bus.IN_MEM_addr[29:ADDR_W];
      dataRdCmd   = dataAccess && bus.IN_MEM_writeEnable;
      dataWrite   = dataAccess && !bus.IN_MEM_writeEnable && !dataOor;
      dataIdx     = bus.IN_MEM_addr[ADDR_W-1:0];

      fetchHiAddr = {bus.IN_instrAddr, 1'b1};
      fetch       = (state == DONE) && !bus.IN_instrReadEnable;
      fetchOor    = |fetchHiAddr[29:ADDR_W];
      fetchLoIdx  = {bus.IN_instrAddr[ADDR_W-2:0], 1'b0};
      fetchHiIdx  = fetchHiAddr[ADDR_W-1:0];

      errSet      = (ldWordDone && ldOor) || (dataAccess && dataOor) || (fetch && fetchOor);
   end

   // Loader FSM with registered handshake and core-enable outputs.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         byteIdx   <= '0;
         asmWord   <= '0;
         ldReady   <= 1'b0;
         coreEn    <= 1'b0;
         ldDone    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.IN_LD_start) begin
                  ptr       <= {1'b0, bus.IN_LD_baseAddr};
                  remaining <= bus.IN_LD_numWords;
                  byteIdx   <= '0;
                  asmWord   <= '0;
                  if (bus.IN_LD_numWords == '0) begin
                     state  <= DONE;
                     coreEn <= 1'b1;
                     ldDone <= 1'b1;
                  end else begin
                     state   <= LOAD;
                     ldReady <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (byteAccept) begin
                  if (byteIdx == 2'd3) begin
                     ptr       <= ptr + 1'b1;
                     remaining <= remaining - 1'b1;
                     byteIdx   <= '0;
                     if (remaining == (ADDR_W+1)'(1)) begin
                        state   <= DONE;
                        ldReady <= 1'b0;
                        coreEn  <= 1'b1;
                        ldDone  <= 1'b1;
                     end
                  end else begin
                     case (byteIdx)
                        2'd0:    asmWord[7:0]   <= bus.IN_LD_byte;
                        2'd1:    asmWord[15:8]  <= bus.IN_LD_byte;
                        default: asmWord[23:16] <= bus.IN_LD_byte;
                     endcase
                     byteIdx <= byteIdx + 1'b1;
                  end
               end
            end
            default: ;  // DONE is terminal until reset
         endcase
      end
   end

   // Storage writes: whole words from the loader, masked bytes from the data port.
   // NOTE: the array deliberately has no reset; contents survive rst so a
   // loaded image stays valid across a core restart.
   always_ff @(posedge clk) begin
      if (ldWrite) begin
         mem[ptr[ADDR_W-1:0]] <= ldWord;
      end else if (dataWrite) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.IN_MEM_writeMask[b]) begin
               mem[dataIdx][b*8 +: 8] <= bus.IN_MEM_writeData[b*8 +: 8];
            end
         end
      end
   end

   // Registered read ports; they see pre-write contents on a same-cycle collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         readData <= '0;
         instrRaw <= '0;
      end else begin
         if (dataRdCmd) begin
            readData <= dataOor ? '0 : mem[dataIdx];
         end
         if (fetch) begin
            instrRaw <= fetchOor ? '0 : {mem[fetchHiIdx], mem[fetchLoIdx]};
         end
      end
   end

   // Sticky out-of-range flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addrError <= 1'b0;
      end else if (errSet) begin
         addrError <= 1'b1;
      end
   end

   assign bus.OUT_MEM_readData = readData;
   assign bus.OUT_instrRaw     = instrRaw;
   assign bus.OUT_LD_ready     = ldReady;
   assign bus.OUT_coreEn       = coreEn;
   assign bus.OUT_LD_done      = ldDone;
   assign bus.OUT_addrError    = addrError;

endmodule

// File: tb/tb_boot_mem_responder.sv
// Scoreboard bench for boot_mem_responder: every driven request pushes its
// expected result, which is popped and compared once the registered output
// appears one edge later.
module tb_boot_mem_responder;

   localparam int ADDR_W = 12;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   boot_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

   boot_mem_responder #(.ADDR_W(ADDR_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      string       tag;
      logic [63:0] val;
   } expT;

   expT         sbQ[$];
   int          checks = 0;
   int          errors = 0;
   bit [31:0]   model [int unsigned];
   logic [31:0] lastRead;
   logic [63:0] lastInstr;
   bit          coreOn;
   bit          expErr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input logic [63:0] val);
      expT e;
      e.tag = tag;
      e.val = val;
      sbQ.push_back(e);
   endtask

   task automatic observe(input logic [63:0] got);
      expT e;
      if (sbQ.size() == 0) begin
         check("sb_underflow", 64'(sbQ.size()), 64'd1);
      end else begin
         e = sbQ.pop_front();
         check(e.tag, got, e.val);
      end
   endtask

   task automatic status(input string tag, input logic [63:0] got, input logic [63:0] exp);
      push(tag, exp);
      observe(got);
   endtask

   function automatic logic [31:0] modelRd(input int unsigned addr);
      if (addr < DEPTH && model.exists(addr)) return model[addr];
      return 32'h0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idleBus();
      bus.IN_MEM_readEnable  = 1'b1;
      bus.IN_MEM_writeEnable = 1'b1;
      bus.IN_MEM_writeMask   = 4'h0;
      bus.IN_instrReadEnable = 1'b1;
      bus.IN_LD_start        = 1'b0;
      bus.IN_LD_valid        = 1'b0;
   endtask

   task automatic doReset(input string tag);
      rst = 1'b1;
      idleBus();
      #1;
      status({tag, "_readData"}, bus.OUT_MEM_readData, 0);
      status({tag, "_instrRaw"}, bus.OUT_instrRaw, 0);
      status({tag, "_ready"}, bus.OUT_LD_ready, 0);
      status({tag, "_coreEn"}, bus.OUT_coreEn, 0);
      status({tag, "_done"}, bus.OUT_LD_done, 0);
      status({tag, "_err"}, bus.OUT_addrError, 0);
      coreOn    = 1'b0;
      expErr    = 1'b0;
      lastRead  = '0;
      lastInstr = '0;
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic dataRead(input string tag, input int unsigned addr);
      logic [31:0] exp;
      exp = coreOn ? modelRd(addr) : lastRead;
      if (coreOn && addr >= DEPTH) expErr = 1'b1;
      bus.IN_MEM_addr        = 30'(addr);
      bus.IN_MEM_readEnable  = 1'b0;
      bus.IN_MEM_writeEnable = 1'b1;
      push(tag, 64'(exp));
      step();
      idleBus();
      observe(64'(bus.OUT_MEM_readData));
      lastRead = exp;
   endtask

   task automatic dataWrite(input string tag, input int unsigned addr,
                            input logic [31:0] data, input logic [3:0] mask);
      bus.IN_MEM_addr        = 30'(addr);
      bus.IN_MEM_writeData   = data;
      bus.IN_MEM_writeMask   = mask;
      bus.IN_MEM_readEnable  = 1'b0;
      bus.IN_MEM_writeEnable = 1'b0;
      push(tag, 64'(lastRead));
      step();
      idleBus();
      observe(64'(bus.OUT_MEM_readData));
      if (coreOn && addr >= DEPTH) expErr = 1'b1;
      if (coreOn && addr < DEPTH) begin
         if (!model.exists(addr)) model[addr] = 32'h0;
         for (int b = 0; b < 4; b++) begin
            if (mask[b]) model[addr][b*8 +: 8] = data[b*8 +: 8];
         end
      end
   endtask

   function automatic logic [63:0] fetchExp(input int unsigned a);
      if (2*a + 1 >= DEPTH) return 64'h0;
      return {modelRd(2*a + 1), modelRd(2*a)};
   endfunction

   task automatic fetch(input string tag, input int unsigned a);
      logic [63:0] exp;
      exp = coreOn ? fetchExp(a) : lastInstr;
      if (coreOn && 2*a + 1 >= DEPTH) expErr = 1'b1;
      bus.IN_instrAddr       = 29'(a);
      bus.IN_instrReadEnable = 1'b0;
      push(tag, exp);
      step();
      idleBus();
      observe(bus.OUT_instrRaw);
      lastInstr = exp;
   endtask

   task automatic ldLoad(input string tag, input int unsigned base,
                         input int unsigned num, input logic [7:0] first);
      int unsigned ptr;
      logic [31:0] word;
      logic [7:0]  b;
      bus.IN_LD_baseAddr = ADDR_W'(base);
      bus.IN_LD_numWords = (ADDR_W+1)'(num);
      bus.IN_LD_start    = 1'b1;
      step();
      bus.IN_LD_start    = 1'b0;
      if (num != 0) begin
         status({tag, "_readyOn"}, bus.OUT_LD_ready, 1);
         ptr = base;
         for (int w = 0; w < int'(num); w++) begin
            word = '0;
            for (int k = 0; k < 4; k++) begin
               b = 8'(int'(first) + w*4 + k);
               bus.IN_LD_valid = 1'b1;
               bus.IN_LD_byte  = b;
               word[k*8 +: 8]  = b;
               step();
            end
            if (ptr < DEPTH) model[ptr] = word;
            else expErr = 1'b1;
            ptr++;
         end
         bus.IN_LD_valid = 1'b0;
      end
      coreOn = 1'b1;
      status({tag, "_coreEn"}, bus.OUT_coreEn, 1);
      status({tag, "_done"}, bus.OUT_LD_done, 1);
      status({tag, "_readyOff"}, bus.OUT_LD_ready, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.IN_MEM_addr      = '0;
      bus.IN_MEM_writeData = '0;
      bus.IN_instrAddr     = '0;
      bus.IN_LD_baseAddr   = '0;
      bus.IN_LD_numWords   = '0;
      bus.IN_LD_byte       = '0;
      idleBus();
      #2;
      doReset("rst0");

      // Requests before the core is enabled are ignored.
      dataRead("pre_rd_hold", 16);
      fetch("pre_fetch_hold", 8);

      // Load two words at 0x10 from bytes 01..08.
      ldLoad("ld1", 'h10, 2, 8'h01);
      dataRead("rd_0x10", 'h10);
      dataRead("rd_0x11", 'h11);
      check("model_0x11", 64'(lastRead), 64'h08070605);
      fetch("fetch_a8_load", 8);

      // Masked write then read back.
      dataWrite("wr5_clear_hold", 5, 32'h0000_0000, 4'hF);
      dataWrite("wr5_mask_hold", 5, 32'hAABB_CCDD, 4'b0101);
      dataRead("rd5_masked", 5);

      // Chip enable high: no access even with write selected.
      bus.IN_MEM_addr        = 30'd5;
      bus.IN_MEM_writeData   = 32'h1234_5678;
      bus.IN_MEM_writeMask   = 4'hF;
      bus.IN_MEM_writeEnable = 1'b0;
      bus.IN_MEM_readEnable  = 1'b1;
      push("ce_off_hold", 64'(lastRead));
      step();
      idleBus();
      observe(64'(bus.OUT_MEM_readData));
      dataRead("rd5_after_ce_off", 5);

      // Fetch pair and hold while disabled.
      dataWrite("wr16", 16, 32'h0000_0011, 4'hF);
      dataWrite("wr17", 17, 32'h0000_0022, 4'hF);
      fetch("fetch_a8", 8);
      for (int i = 0; i < 3; i++) begin
         bus.IN_instrAddr = 29'($urandom_range(0, 1000));
         push("fetch_hold", lastInstr);
         step();
         observe(bus.OUT_instrRaw);
      end

      // Same-cycle write and fetch of word 16 returns pre-write data.
      bus.IN_MEM_addr        = 30'd16;
      bus.IN_MEM_writeData   = 32'hFFFF_FFFF;
      bus.IN_MEM_writeMask   = 4'hF;
      bus.IN_MEM_readEnable  = 1'b0;
      bus.IN_MEM_writeEnable = 1'b0;
      bus.IN_instrAddr       = 29'd8;
      bus.IN_instrReadEnable = 1'b0;
      push("coll_fetch_old", 64'h0000_0022_0000_0011);
      step();
      idleBus();
      observe(bus.OUT_instrRaw);
      lastInstr  = 64'h0000_0022_0000_0011;
      model[16]  = 32'hFFFF_FFFF;
      fetch("coll_fetch_new", 8);

      // Top-of-range accesses stay in range.
      dataWrite("wr_top", DEPTH - 1, 32'hCAFE_F00D, 4'hF);
      dataWrite("wr_top_m1", DEPTH - 2, 32'h1357_9BDF, 4'hF);
      dataRead("rd_top", DEPTH - 1);
      fetch("fetch_top", DEPTH/2 - 1);
      status("err_in_range", bus.OUT_addrError, expErr);

      // Out-of-range: zero data, dropped writes, no wrap, sticky flag.
      dataWrite("wr0", 0, 32'h0BAD_0000, 4'hF);
      dataRead("rd_oor", DEPTH);
      status("err_set", bus.OUT_addrError, expErr);
      dataWrite("wr_oor", DEPTH, 32'hFFFF_FFFF, 4'hF);
      dataRead("rd0_no_wrap", 0);
      fetch("fetch_oor", DEPTH/2);
      status("err_sticky", bus.OUT_addrError, expErr);

      // Reset keeps memory; writes before DONE dropped; zero-length load.
      doReset("rst1");
      dataWrite("idle_wr_hold", 5, 32'hFFFF_FFFF, 4'hF);
      fetch("idle_fetch_hold", 2);
      ldLoad("ld_zero", 0, 0, 8'h00);
      dataRead("rd5_kept", 5);

      // Reset mid-load abandons the partial word; stray bytes ignored.
      doReset("rst2");
      bus.IN_LD_baseAddr = ADDR_W'('h30);
      bus.IN_LD_numWords = (ADDR_W+1)'(1);
      bus.IN_LD_start    = 1'b1;
      step();
      bus.IN_LD_start    = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.IN_LD_valid = 1'b1;
         bus.IN_LD_byte  = 8'hA1 + 8'(k);
         step();
      end
      doReset("rst_mid_load");
      for (int i = 0; i < 4; i++) begin
         bus.IN_LD_valid = 1'b1;
         bus.IN_LD_byte  = 8'hEE;
         step();
         status("burst_ready", bus.OUT_LD_ready, 0);
         status("burst_coreEn", bus.OUT_coreEn, 0);
      end
      bus.IN_LD_valid = 1'b0;
      ldLoad("ld_after_rst", 'h30, 1, 8'hB1);
      dataRead("rd_0x30", 'h30);

      // Loader running past the top drops the word and flags the error.
      doReset("rst3");
      ldLoad("ld_oor", DEPTH - 1, 2, 8'hC0);
      status("ld_oor_err", bus.OUT_addrError, expErr);
      dataRead("rd_top_ld", DEPTH - 1);
      dataRead("rd0_ld_no_wrap", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
